// File: rtl/score_table_if.sv
// Purpose: game-side inputs and display-side outputs of the score table.
// Ports: GAME_STATE/SEC/MSEC10/SHOW flow into the table; DISP_*, ENTRIES and
//        NEW_RECORD flow out. master = game/display side, slave = score_table.
interface score_table_if;
   logic [1:0] GAME_STATE;
   logic [4:0] SEC;
   logic [6:0] MSEC10;
   logic       SHOW;
   logic [4:0] DISP_SEC;
   logic [6:0] DISP_MSEC10;
   logic [1:0] DISP_RANK;
   logic       DISP_VALID;
   logic [2:0] ENTRIES;
   logic       NEW_RECORD;

   modport master (
      output GAME_STATE, SEC, MSEC10, SHOW,
      input  DISP_SEC, DISP_MSEC10, DISP_RANK, DISP_VALID, ENTRIES, NEW_RECORD
   );

   modport slave (
      input  GAME_STATE, SEC, MSEC10, SHOW,
      output DISP_SEC, DISP_MSEC10, DISP_RANK, DISP_VALID, ENTRIES, NEW_RECORD
   );
endinterface

// File: rtl/score_table.sv
// Purpose: captures the run time of each finished game into a top-DEPTH table
//          sorted longest-first; SHOW steps the display through the ranks.
// Latency: a score is visible 2 edges after GAME_STATE==3 is first sampled.
// Flow:    no backpressure; one capture per game, SHOW honoured every cycle.
// Ports:   CLK, RESET (sync, active-low, system clear), bus (score_table_if.slave).
// Option:  SCORE_BLINK_EN makes NEW_RECORD blink every BLINK_DIV cycles
//          (starting high); otherwise NEW_RECORD is a steady level.
module score_table #(
   parameter int DEPTH     = 3,
   parameter int CNT_1SEC  = 100,
   parameter int BLINK_DIV = 25000000
) (
   input  logic         CLK,
   input  logic         RESET,
   score_table_if.slave bus
);

   typedef enum logic [1:0] {ARMED, RUNNING, INSERT, HOLD} state_t;

   state_t     state, state_nxt;
   logic       cap_en, rec_clr;
   logic [4:0] cap_sec;
   logic [6:0] cap_msec10;

   logic [4:0] tab_sec    [DEPTH];
   logic [6:0] tab_msec10 [DEPTH];
   logic       tab_vld    [DEPTH];
   logic [2:0] entries;
   logic [1:0] idx;
   logic       rec_lvl;

   logic       ins_ok;
   logic [2:0] ins_pos;
   logic [11:0] new_tot;

   function automatic logic [11:0] to_total(input logic [4:0] s, input logic [6:0] m);
      return 12'(s) * 12'(CNT_1SEC) + 12'(m);
   endfunction

   // ---------------- game-tracking FSM ----------------
   always_ff @(posedge CLK) begin
      if (!RESET) state <= ARMED;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cap_en    = 1'b0;
      rec_clr   = 1'b0;
      case (state)
         ARMED: if (bus.GAME_STATE == 2'd1) begin
            state_nxt = RUNNING;
            rec_clr   = 1'b1;
         end
         RUNNING: if (bus.GAME_STATE == 2'd3) begin
            state_nxt = INSERT;
            cap_en    = 1'b1;
         end else if (bus.GAME_STATE == 2'd0) begin
            state_nxt = ARMED;
         end
         INSERT:  state_nxt = HOLD;
         HOLD:    if (bus.GAME_STATE == 2'd0) state_nxt = ARMED;
         default: state_nxt = ARMED;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         cap_sec    <= '0;
         cap_msec10 <= '0;
      end else if (cap_en) begin
         cap_sec    <= bus.SEC;
         cap_msec10 <= bus.MSEC10;
      end
   end

   // ---------------- insertion point ----------------
   // Valid entries are contiguous from slot 0, so the first slot that is empty
   // or strictly smaller is the insertion point. Strict '<' keeps equal older
   // entries above the new one. Scanning downward leaves the lowest hit.
   assign new_tot = to_total(cap_sec, cap_msec10);

   always_comb begin
      ins_ok  = 1'b0;
      ins_pos = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!tab_vld[i] || (to_total(tab_sec[i], tab_msec10[i]) < new_tot)) begin
            ins_ok  = 1'b1;
            ins_pos = 3'(i);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         for (int i = 0; i < DEPTH; i++) begin
            tab_sec[i]    <= '0;
            tab_msec10[i] <= '0;
            tab_vld[i]    <= 1'b0;
         end
         entries <= '0;
      end else if (state == INSERT && ins_ok) begin
         // Shift below the insertion point; the old last slot falls off.
         for (int i = 1; i < DEPTH; i++) begin
            if (3'(i) > ins_pos) begin
               tab_sec[i]    <= tab_sec[i-1];
               tab_msec10[i] <= tab_msec10[i-1];
               tab_vld[i]    <= tab_vld[i-1];
            end
         end
         for (int i = 0; i < DEPTH; i++) begin
            if (3'(i) == ins_pos) begin
               tab_sec[i]    <= cap_sec;
               tab_msec10[i] <= cap_msec10;
               tab_vld[i]    <= 1'b1;
            end
         end
         if (entries < 3'(DEPTH)) entries <= entries + 3'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET)               rec_lvl <= 1'b0;
      else if (rec_clr)         rec_lvl <= 1'b0;
      else if (state == INSERT) rec_lvl <= ins_ok && (ins_pos == 3'd0);
   end

   // ---------------- display ----------------
   always_ff @(posedge CLK) begin
      if (!RESET)             idx <= '0;
      else if (!bus.SHOW)     idx <= (idx == 2'(DEPTH - 1)) ? 2'd0 : idx + 2'd1;
   end

   always_comb begin
      bus.DISP_SEC    = '0;
      bus.DISP_MSEC10 = '0;
      bus.DISP_VALID  = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (idx == 2'(i) && tab_vld[i]) begin
            bus.DISP_SEC    = tab_sec[i];
            bus.DISP_MSEC10 = tab_msec10[i];
            bus.DISP_VALID  = 1'b1;
         end
      end
   end

   assign bus.DISP_RANK = idx;
   assign bus.ENTRIES   = entries;

`ifdef SCORE_BLINK_EN
   localparam int BW = $clog2(BLINK_DIV + 1);
   logic [BW-1:0] blink_cnt;
   logic          blink_q;

   // Held at count 0 / high while no record, so each record starts lit.
   always_ff @(posedge CLK) begin
      if (!RESET || !rec_lvl) begin
         blink_cnt <= '0;
         blink_q   <= 1'b1;
      end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
         blink_cnt <= '0;
         blink_q   <= ~blink_q;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   assign bus.NEW_RECORD = rec_lvl & blink_q;
`else
   assign bus.NEW_RECORD = rec_lvl;
`endif

endmodule

// File: tb/tb_score_table.sv
// Purpose: directed checks of score_table (DEPTH=3): capture latency, sorting,
//          discard, ties, display stepping, single capture, abort, reset.
// Ports:   drives the master side of score_table_if; CLK and RESET generated here.
module tb_score_table;

   logic CLK = 1'b0;
   logic RESET = 1'b0;
   always #5 CLK = ~CLK;

   score_table_if bus ();

   score_table #(.DEPTH(3), .CNT_1SEC(100), .BLINK_DIV(8)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int cur_idx = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RESET = 1'b0;
      @(negedge CLK);
      RESET = 1'b1;
      cur_idx = 0;
   endtask

   task automatic show_pulse();
      @(negedge CLK);
      bus.SHOW = 1'b0;
      @(negedge CLK);
      bus.SHOW = 1'b1;
      cur_idx = (cur_idx == 2) ? 0 : cur_idx + 1;
   endtask

   // Full game from any state: 0 -> 1 -> 3 (held), then wait for the insert.
   task automatic play(input int s, input int m);
      @(negedge CLK); bus.GAME_STATE = 2'd0;
      @(negedge CLK); bus.GAME_STATE = 2'd1;
      @(negedge CLK); bus.GAME_STATE = 2'd3; bus.SEC = 5'(s); bus.MSEC10 = 7'(m);
      cyc(2);
   endtask

   task automatic chk_entry(input string tag, input int r, input int v,
                            input int s, input int m);
      for (int k = 0; k < 4 && cur_idx != r; k++) show_pulse();
      chk({tag, ".rank"},  int'(bus.DISP_RANK), r);
      chk({tag, ".valid"}, int'(bus.DISP_VALID), v);
      chk({tag, ".sec"},   int'(bus.DISP_SEC), s);
      chk({tag, ".ms10"},  int'(bus.DISP_MSEC10), m);
   endtask

   initial begin
      bus.GAME_STATE = 2'd0;
      bus.SEC        = '0;
      bus.MSEC10     = '0;
      bus.SHOW       = 1'b1;
      do_reset();
      cyc(1);

      // Reset state
      chk("rst.entries", int'(bus.ENTRIES), 0);
      chk("rst.newrec",  int'(bus.NEW_RECORD), 0);
      chk_entry("rst", 0, 0, 0, 0);

      // 1: first game, latency of 2 edges after state 3
      @(negedge CLK); bus.GAME_STATE = 2'd1;
      @(negedge CLK); bus.GAME_STATE = 2'd3; bus.SEC = 5'd5; bus.MSEC10 = 7'd20;
      cyc(1);
      chk("t1.entries_1edge", int'(bus.ENTRIES), 0);
      cyc(1);
      chk("t1.entries", int'(bus.ENTRIES), 1);
      chk("t1.newrec",  int'(bus.NEW_RECORD), 1);
      chk_entry("t1.r0", 0, 1, 5, 20);
      chk_entry("t1.r1_empty", 1, 0, 0, 0);

      // 2: second, smaller score
      play(3, 50);
      chk("t2.entries", int'(bus.ENTRIES), 2);
      chk("t2.newrec",  int'(bus.NEW_RECORD), 0);
      chk_entry("t2.r0", 0, 1, 5, 20);
      chk_entry("t2.r1", 1, 1, 3, 50);

      // 3: fill, discard, then new best drops the old last
      play(2, 0);
      chk("t3.entries_full", int'(bus.ENTRIES), 3);
      play(1, 0);
      chk("t3.entries_disc", int'(bus.ENTRIES), 3);
      chk_entry("t3.disc_r2", 2, 1, 2, 0);
      play(9, 99);
      chk("t3.newrec", int'(bus.NEW_RECORD), 1);
      chk_entry("t3.r0", 0, 1, 9, 99);
      chk_entry("t3.r1", 1, 1, 5, 20);
      chk_entry("t3.r2", 2, 1, 3, 50);
      // Equal to the last entry on a full table: discarded
      play(3, 50);
      chk("t3.eq_last_newrec", int'(bus.NEW_RECORD), 0);
      chk_entry("t3.eq_r2", 2, 1, 3, 50);

      // 4: tie with rank 0 goes below it, no new record
      do_reset();
      play(4, 0);
      chk("t4.first_newrec", int'(bus.NEW_RECORD), 1);
      play(4, 0);
      chk("t4.entries", int'(bus.ENTRIES), 2);
      chk("t4.newrec",  int'(bus.NEW_RECORD), 0);
      chk_entry("t4.r0", 0, 1, 4, 0);
      chk_entry("t4.r1", 1, 1, 4, 0);
      chk_entry("t4.r2_empty", 2, 0, 0, 0);

      // 5: three SHOW pulses from rank 0 -> 1, 2, 0
      for (int k = 0; k < 4 && cur_idx != 0; k++) show_pulse();
      show_pulse(); chk("t5.rank_a", int'(bus.DISP_RANK), 1);
      show_pulse(); chk("t5.rank_b", int'(bus.DISP_RANK), 2);
      chk("t5.empty_valid", int'(bus.DISP_VALID), 0);
      show_pulse(); chk("t5.rank_c", int'(bus.DISP_RANK), 0);

      // 6a: state 3 held for 100 cycles -> one insertion
      do_reset();
      @(negedge CLK); bus.GAME_STATE = 2'd1;
      @(negedge CLK); bus.GAME_STATE = 2'd3; bus.SEC = 5'd7; bus.MSEC10 = 7'd7;
      cyc(100);
      chk("t6.hold_entries", int'(bus.ENTRIES), 1);
      // 6b: aborted run stores nothing
      @(negedge CLK); bus.GAME_STATE = 2'd0;
      @(negedge CLK); bus.GAME_STATE = 2'd1; bus.SEC = 5'd8;
      @(negedge CLK); bus.GAME_STATE = 2'd0;
      cyc(3);
      chk("t6.abort_entries", int'(bus.ENTRIES), 1);
      chk_entry("t6.abort_r0", 0, 1, 7, 7);
      // 6c: reset during INSERT -> empty table, FSM back in ARMED
      @(negedge CLK); bus.GAME_STATE = 2'd1;
      @(negedge CLK); bus.GAME_STATE = 2'd3; bus.SEC = 5'd6; bus.MSEC10 = 7'd0;
      @(negedge CLK); RESET = 1'b0;
      @(negedge CLK); RESET = 1'b1; cur_idx = 0;
      chk("t6.rst_entries", int'(bus.ENTRIES), 0);
      chk_entry("t6.rst_r0", 0, 0, 0, 0);
      // ARMED accepts 1 directly (HOLD would need a 0 first)
      bus.GAME_STATE = 2'd1;
      @(negedge CLK); bus.GAME_STATE = 2'd3; bus.SEC = 5'd2; bus.MSEC10 = 7'd2;
      cyc(2);
      chk("t6.armed_entries", int'(bus.ENTRIES), 1);
      chk_entry("t6.armed_r0", 0, 1, 2, 2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
